// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared MIPS pipeline widths, ALUOp encodings and register constants
package id_ex_stage_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    typedef enum logic [1:0] {
        ALU_MEM = 2'b00,
        ALU_BR  = 2'b01,
        ALU_R   = 2'b10,
        ALU_IMM = 2'b11
    } aluop_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX is still fetching
module load_use_detect
    import id_ex_stage_pkg::*;
#(
    parameter int RW = RW_DEF
) (
    input  logic          ex_valid,
    input  logic          ex_memread,
    input  logic [RW-1:0] ex_rt,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    output logic          lu
);

    assign lu = ex_valid & ex_memread & id_valid & (ex_rt != RW'(REG_ZERO)) &
                ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, hold and flush
// Optional ID_EX_PERF_EN adds saturating bubble_cnt / hold_cnt counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_regdst,
    input  logic          id_alusrc,
    input  logic          id_memtoreg,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_branch,
    input  logic          id_jrcontrol,
    input  logic [1:0]    id_aluop,
    input  logic          id_valid,
    input  logic          id_flush,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          hold,
    output logic          ex_regdst,
    output logic          ex_alusrc,
    output logic          ex_memtoreg,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_branch,
    output logic          ex_jrcontrol,
    output logic [1:0]    ex_aluop,
    output logic          ex_valid,
    output logic [DW-1:0] ex_rdata1,
    output logic [DW-1:0] ex_rdata2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic          stall_out
`ifdef ID_EX_PERF_EN
    ,
    output logic [15:0]   bubble_cnt,
    output logic [15:0]   hold_cnt
`endif
);

    localparam int W = 11 + 4 * DW + 3 * RW;

    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         lu;
    logic         bubble;

    assign d = {id_valid, id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread,
                id_memwrite, id_branch, id_jrcontrol, id_aluop,
                id_rdata1, id_rdata2, id_imm, id_pc4, id_rs, id_rt, id_rd};

    assign {ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
            ex_memwrite, ex_branch, ex_jrcontrol, ex_aluop,
            ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd} = q;

    load_use_detect #(.RW(RW)) u_lu (
        .ex_valid   (ex_valid),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .lu         (lu)
    );

    assign bubble    = id_flush | lu;
    assign stall_out = lu | hold;

    // Pipeline register: reset clears, hold freezes, flush/load-use inserts an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (!hold)
            q <= bubble ? '0 : d;
    end

`ifdef ID_EX_PERF_EN
    // Saturating counts of bubble-insert edges and held edges
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            if (!hold && bubble && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
            if (hold && hold_cnt != 16'hFFFF)
                hold_cnt <= hold_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, corner sequences and randomized reference-model check of id_ex_stage
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        regdst;
        logic        alusrc;
        logic        memtoreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jrcontrol;
        logic [1:0]  aluop;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ex_t;

    typedef struct {
        logic        rst, hold, flush, valid, mr, rw, mw;
        logic [4:0]  rs, rt;
        logic [31:0] d;
        logic        es, ev, erw, emw, emr;
        logic [4:0]  ert;
        logic [31:0] ed;
    } row_t;

    logic clk = 1'b0;
    logic reset, hold, flush;
    ex_t  id, act, m, x;
    int   checks = 0;
    int   failures = 0;

    logic        ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
    logic        ex_branch, ex_jrcontrol, ex_valid, stall_out;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_PERF_EN
    logic [15:0] bubble_cnt, hold_cnt;
    int          mb, mh;
`endif

    always #5 clk = ~clk;

    assign act = {ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                  ex_memwrite, ex_branch, ex_jrcontrol, ex_aluop,
                  ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd};

    id_ex_stage dut (
        .clk          (clk),
        .reset        (reset),
        .id_regdst    (id.regdst),
        .id_alusrc    (id.alusrc),
        .id_memtoreg  (id.memtoreg),
        .id_regwrite  (id.regwrite),
        .id_memread   (id.memread),
        .id_memwrite  (id.memwrite),
        .id_branch    (id.branch),
        .id_jrcontrol (id.jrcontrol),
        .id_aluop     (id.aluop),
        .id_valid     (id.valid),
        .id_flush     (flush),
        .id_rdata1    (id.rdata1),
        .id_rdata2    (id.rdata2),
        .id_imm       (id.imm),
        .id_pc4       (id.pc4),
        .id_rs        (id.rs),
        .id_rt        (id.rt),
        .id_rd        (id.rd),
        .hold         (hold),
        .ex_regdst    (ex_regdst),
        .ex_alusrc    (ex_alusrc),
        .ex_memtoreg  (ex_memtoreg),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_branch    (ex_branch),
        .ex_jrcontrol (ex_jrcontrol),
        .ex_aluop     (ex_aluop),
        .ex_valid     (ex_valid),
        .ex_rdata1    (ex_rdata1),
        .ex_rdata2    (ex_rdata2),
        .ex_imm       (ex_imm),
        .ex_pc4       (ex_pc4),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .stall_out    (stall_out)
`ifdef ID_EX_PERF_EN
        ,
        .bubble_cnt   (bubble_cnt),
        .hold_cnt     (hold_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    function automatic ex_t rnd_id();
        logic [159:0] r;
        ex_t t;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        t = r[153:0];
        t.valid   = $urandom_range(0, 4) != 0;
        t.memread = $urandom_range(0, 9) < 4;
        t.rs      = 5'($urandom_range(0, 3));
        t.rt      = 5'($urandom_range(0, 3));
        return t;
    endfunction

    // Spec rule: loaded EX instruction stalls a dependent ID instruction, $0 excepted
    function automatic logic ref_lu(input ex_t e, input ex_t i);
        return e.valid && e.memread && i.valid && e.rt != 0 && (e.rt == i.rs || e.rt == i.rt);
    endfunction

    row_t rows[22];

    initial begin
        rows = '{
            '{1,0,0,1,1,1,0, 3,8, 32'h0000AAAA, 0, 0,0,0,0, 0, 32'h0},
            '{0,0,0,1,1,1,0, 3,8, 32'h00001111, 0, 1,1,0,1, 8, 32'h00001111},
            '{0,0,0,1,0,1,0, 8,9, 32'h12345678, 1, 0,0,0,0, 0, 32'h0},
            '{0,0,0,1,0,1,0, 8,9, 32'h12345678, 0, 1,1,0,0, 9, 32'h12345678},
            '{0,0,0,1,1,1,0, 1,0, 32'h00002222, 0, 1,1,0,1, 0, 32'h00002222},
            '{0,0,0,1,0,1,0, 0,0, 32'h00003333, 0, 1,1,0,0, 0, 32'h00003333},
            '{0,0,1,1,0,0,1, 2,3, 32'h00004444, 0, 0,0,0,0, 0, 32'h0},
            '{0,0,0,1,1,1,0, 1,5, 32'h00005555, 0, 1,1,0,1, 5, 32'h00005555},
            '{0,1,0,1,0,1,0, 5,6, 32'h00006666, 1, 1,1,0,1, 5, 32'h00005555},
            '{0,0,0,1,0,1,0, 5,6, 32'h00006666, 1, 0,0,0,0, 0, 32'h0},
            '{0,0,0,1,0,1,0, 5,6, 32'h00006666, 0, 1,1,0,0, 6, 32'h00006666},
            '{0,0,0,0,0,1,0, 1,2, 32'h00007777, 0, 0,1,0,0, 2, 32'h00007777},
            '{0,0,0,1,1,1,0, 1,7, 32'h00008888, 0, 1,1,0,1, 7, 32'h00008888},
            '{1,0,0,1,0,1,0, 7,2, 32'h00009999, 1, 0,0,0,0, 0, 32'h0},
            '{0,0,0,1,0,1,0, 7,2, 32'h00009999, 0, 1,1,0,0, 2, 32'h00009999},
            '{0,0,0,1,1,1,0, 1,9, 32'hAAAA0001, 0, 1,1,0,1, 9, 32'hAAAA0001},
            '{0,0,0,1,1,1,0, 9,9, 32'h0000BBBB, 1, 0,0,0,0, 0, 32'h0},
            '{0,0,0,1,1,1,0, 9,9, 32'h0000BBBB, 0, 1,1,0,1, 9, 32'h0000BBBB},
            '{0,0,0,1,1,1,0, 9,9, 32'h0000BBBB, 1, 0,0,0,0, 0, 32'h0},
            '{0,0,0,1,1,1,0, 9,9, 32'h0000BBBB, 0, 1,1,0,1, 9, 32'h0000BBBB},
            '{0,0,0,0,0,0,0, 9,9, 32'h00000001, 0, 0,0,0,0, 9, 32'h00000001},
            '{0,0,0,1,0,0,1, 2,3, 32'h0000000C, 0, 1,0,1,0, 3, 32'h0000000C}
        };

        reset = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        id    = rnd_id();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 256'(act), 256'(0));
        @(negedge clk);
        chk("reset_stall", 256'(stall_out), 256'(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            id          = rnd_id();
            id.valid    = rows[i].valid;
            id.memread  = rows[i].mr;
            id.regwrite = rows[i].rw;
            id.memwrite = rows[i].mw;
            id.rs       = rows[i].rs;
            id.rt       = rows[i].rt;
            id.rdata1   = rows[i].d;
            id.aluop    = 2'b10;
            reset       = rows[i].rst;
            hold        = rows[i].hold;
            flush       = rows[i].flush;
            @(negedge clk);
            chk($sformatf("row%0d_stall", i), 256'(stall_out), 256'(rows[i].es));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_ex", i),
                256'({ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_rt, ex_rdata1}),
                256'({rows[i].ev, rows[i].erw, rows[i].emw, rows[i].emr, rows[i].ert, rows[i].ed}));
        end

        reset = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        x         = rnd_id();
        x.valid   = 1'b1;
        x.memread = 1'b0;
        id        = x;
        @(posedge clk);
        #1;
        chk("hf_load", 256'(act), 256'(x));
        hold  = 1'b1;
        flush = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id = rnd_id();
            @(negedge clk);
            chk($sformatf("hf_stall%0d", k), 256'(stall_out), 256'(1));
            @(posedge clk);
            #1;
            chk($sformatf("hf_keep%0d", k), 256'(act), 256'(x));
        end
        hold = 1'b0;
        @(posedge clk);
        #1;
        chk("hf_bubble", 256'(act), 256'(0));
`ifdef ID_EX_PERF_EN
        chk("hf_hold_cnt", 256'(hold_cnt), 256'(3));
        chk("hf_bubble_cnt", 256'(bubble_cnt), 256'(1));
        mb = 1;
        mh = 3;
`endif

        m = '0;
        for (int c = 0; c < 3000; c++) begin
            logic lu;
            reset = $urandom_range(0, 49) == 0;
            hold  = $urandom_range(0, 4) == 0;
            flush = $urandom_range(0, 7) == 0;
            id    = rnd_id();
            lu    = ref_lu(m, id);
            @(negedge clk);
            chk($sformatf("rnd%0d_stall", c), 256'(stall_out), 256'(lu | hold));
`ifdef ID_EX_PERF_EN
            if (reset) begin
                mb = 0;
                mh = 0;
            end else if (hold) begin
                mh = (mh < 65535) ? mh + 1 : mh;
            end else if (flush || lu) begin
                mb = (mb < 65535) ? mb + 1 : mb;
            end
`endif
            if (reset)
                m = '0;
            else if (!hold)
                m = (flush || lu) ? ex_t'(0) : id;
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_ex", c), 256'(act), 256'(m));
`ifdef ID_EX_PERF_EN
            chk($sformatf("rnd%0d_cnt", c), 256'({bubble_cnt, hold_cnt}),
                256'({16'(mb), 16'(mh)}));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
